ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage; consumes operands held in the ID/EX pipeline register.
//  Latches rs1/rs2/funct3/rd on accept, then runs XLEN radix-2 iterations.
//  Returns a one-cycle result strobe to EX/MEM.
//  Drives busy so the hazard logic deasserts ID/EX en (stall) until the result is ready.
// PARAMETERS
//  XLEN      32   operand/result width; power of two, >= 8
//  CNT_W     $clog2(XLEN)   localparam, iteration counter width
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  valid_in   in   1     ID/EX holds an M-extension instruction
//  funct3     in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1        in   XLEN  operand A from ID/EX
//  rs2        in   XLEN  operand B from ID/EX
//  rd_in      in   5     destination register from ID/EX
//  flush      in   1     branch/trap kill of the EX-stage instruction
//  busy       out  1     stall request; ID/EX en = ~busy
//  valid_out  out  1     result valid, exactly one cycle per accepted op
//  result     out  XLEN  product/quotient/remainder
//  rd_out     out  5     latched rd, paired with result
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; result, rd_out, counter, datapath regs = 0; valid_out=0.
//  - busy is 0 while rst is high.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    - IDLE: accept when valid_in & ~flush.
//      - On accept: latch funct3, rd_in, |rs1|, |rs2| (signed ops only), result sign.
//      - Go to CALC, or straight to DONE for special cases.
//    - CALC: one iteration per cycle; counter XLEN-1 down to 0; go to DONE on counter==0.
//    - DONE: valid_out=1; result and rd_out stable; busy=0; next state always IDLE.
//      - DONE never accepts: ID/EX advances on this edge, so the same instruction is not re-taken.
//  - busy = (IDLE & valid_in & ~flush) | CALC; combinational, so the accept cycle already stalls.
//  - Latency, accept cycle = 0:
//    - Normal op: valid_out in cycle XLEN+1; busy high for cycles 0..XLEN.
//    - Special case: valid_out in cycle 1.
//  - MUL: shift-add into a 2*XLEN accumulator. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
//  - MULHSU: only rs1 is treated as signed.
//  - Signed fixup: negate the 2*XLEN product, or quotient/remainder, on the final cycle.
//    - Quotient sign = sign(rs1)^sign(rs2); remainder sign = sign(rs1).
//  - DIV/REM: restoring division, one quotient bit per cycle.
//  - Special cases (bypass CALC, RISC-V spec values):
//    - rs2==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//    - DIV with rs1 = -2^(XLEN-1) and rs2 = -1 -> rs1; REM -> 0.
//  - flush:
//    - In IDLE: blocks accept.
//    - In CALC: abort; next state IDLE, no valid_out.
//    - In DONE: valid_out is forced 0 that cycle; go to IDLE.
//  - valid_out = (state==DONE) & ~flush.
//  - rst asserted mid-operation: abort immediately; no valid_out after release.
//  - All arithmetic is unsigned on magnitudes; no X propagation from unused operand bits.
// STRUCTURE
//  - riscv_pkg: MULDIV funct3 localparams, state encoding (IDLE/CALC/DONE), XLEN default.
//  - Sub-module ex_muldiv_step: combinational single iteration.
//    - Multiply: conditional add + shift.
//    - Divide: trial subtract + shift.
//    - Selected by an is_div input.
//  - The FSM, counter, sign handling and special-case detection stay in ex_muldiv_unit.
// TESTING
//  1. MUL rs1=7, rs2=-3 (0xFFFFFFFD)
//     -> result 0xFFFFFFEB; valid_out exactly 33 cycles after accept; busy high cycles 0..32.
//  2. MULH 0x80000000 * 0x80000000 -> 0x40000000.
//     MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
//     DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//     DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//     Each with valid_out in cycle 1.
//  5. flush at CALC iteration 10 -> no valid_out; busy low next cycle.
//     New DIVU 9/3 accepted after that -> 3.
//  6. rst pulsed mid-CALC -> all outputs 0 immediately.
//     valid_in held through the DONE cycle -> exactly one valid_out, rd_out = rd_in.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   XLEN_DEFAULT : default operand width
//   F3_*         : M-extension funct3 encodings
//   md_state_e   : sequencer states of ex_muldiv_unit
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_step.sv
// One combinational radix-2 iteration on a 2*XLEN accumulator {hi, lo}.
//   i_is_div : 0 = multiply step, 1 = restoring-divide step
//   i_acc    : accumulator; multiply: {partial product, multiplier},
//              divide: {partial remainder, dividend/quotient}
//   i_opb    : multiplicand (multiply) or divisor (divide) magnitude
//   o_acc    : accumulator after this iteration
module ex_muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic                i_is_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]     i_opb,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_part;
    logic [XLEN:0]   w_trial;

    assign w_hi = i_acc[2*XLEN-1:XLEN];
    assign w_lo = i_acc[XLEN-1:0];

    // Multiply: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right keeping the carry.
    assign w_sum = {1'b0, w_hi} + ({1'b0, i_opb} & {(XLEN+1){w_lo[0]}});

    // Divide: shift the next dividend bit into the remainder and try a
    // subtract; the borrow bit (MSB) decides restore vs. keep.
    assign w_part  = {w_hi, w_lo[XLEN-1]};
    assign w_trial = w_part - {1'b0, i_opb};

    always_comb begin
        o_acc = '0;
        if (!i_is_div) begin
            o_acc = {w_sum, w_lo[XLEN-1:1]};
        end else if (!w_trial[XLEN]) begin
            o_acc = {w_trial[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
        end else begin
            o_acc = {w_part[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
//   clk, rst   : clock, asynchronous active-high reset
//   valid_in   : ID/EX holds an M-extension instruction
//   funct3     : MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   rs1, rs2   : operands from ID/EX
//   rd_in      : destination register from ID/EX
//   flush      : kill of the EX-stage instruction
//   busy       : stall request (ID/EX en = ~busy)
//   valid_out  : one-cycle result strobe
//   result     : product high/low half, quotient or remainder
//   rd_out     : destination register paired with result
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e           r_state;
    md_state_e           w_next_state;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic [2:0]          r_f3;
    logic                r_neg;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd;

    logic                w_accept;
    logic                w_iterate;
    logic                w_is_div;
    logic                w_sgn1;
    logic                w_sgn2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_val;
    logic [2*XLEN-1:0]   w_step_acc;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_final;

    // Operand decode at accept time
    assign w_is_div = funct3[2];
    assign w_sgn1   = rs1[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                                     (funct3 == F3_DIV)  | (funct3 == F3_REM));
    assign w_sgn2   = rs2[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_DIV) |
                                     (funct3 == F3_REM));
    assign w_mag1   = w_sgn1 ? -rs1 : rs1;
    assign w_mag2   = w_sgn2 ? -rs2 : rs2;

    assign w_div_zero = w_is_div & (rs2 == '0);
    // funct3[0]==0 selects the signed DIV/REM pair
    assign w_div_ovf  = w_is_div & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    assign w_special  = w_div_zero | w_div_ovf;

    always_comb begin
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = funct3[1] ? rs1 : '1;
        end else if (w_div_ovf) begin
            w_special_val = funct3[1] ? '0 : rs1;
        end
    end

    ex_muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .i_is_div (r_f3[2]),
        .i_acc    (r_acc),
        .i_opb    (r_opb),
        .o_acc    (w_step_acc)
    );

    // Sign fixup is applied to the last iteration's output so the final
    // value is registered on the same edge that enters DONE.
    assign w_prod_fix = r_neg ? -w_step_acc : w_step_acc;
    assign w_quo_fix  = r_neg ? -w_step_acc[XLEN-1:0] : w_step_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg ? -w_step_acc[2*XLEN-1:XLEN] : w_step_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_f3)
            F3_MUL:                          w_final = w_prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:    w_final = w_prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                 w_final = w_quo_fix;
            default:                         w_final = w_rem_fix;
        endcase
    end

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_iterate    = 1'b0;
        busy         = 1'b0;
        valid_out    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_in && !flush) begin
                    w_accept     = 1'b1;
                    busy         = ~rst;
                    w_next_state = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = ~rst;
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_iterate = 1'b1;
                    if (r_cnt == '0) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                valid_out    = ~flush;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (w_accept) begin
            r_acc <= {{XLEN{1'b0}}, w_mag1};
            r_opb <= w_mag2;
            r_f3  <= funct3;
            // remainder follows the dividend sign, everything else the xor
            r_neg <= (funct3 == F3_REM) ? w_sgn1 : (w_sgn1 ^ w_sgn2);
            r_cnt <= '1;
            r_rd  <= rd_in;
            if (w_special) begin
                r_result <= w_special_val;
            end
        end else if (w_iterate) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_result <= w_final;
            end
        end
    end

    assign result = r_result;
    assign rd_out = r_rd;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        valid_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    ex_muldiv_unit #(
        .XLEN(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .valid_out (valid_out),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M semantics in 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic [63:0] ua64;
        logic [63:0] ub64;
        int          si;
        int          sj;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'({32'h0, b});
        ua64 = {32'h0, a};
        ub64 = {32'h0, b};
        si   = $signed(a);
        sj   = $signed(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
                return si / sj;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return si % sj;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_NEG;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one op starting on a negedge with the unit idle; returns what
    // was observed. Ends on a negedge with the unit idle again.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input int exp_lat,
                            output logic [31:0] res, output logic [4:0] rdo,
                            output int lat, output int busy_bad, output int nvalid);
        res = '0; rdo = '0; lat = -1; busy_bad = 0; nvalid = 0;
        valid_in = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
        #1;
        if (busy !== 1'b1) busy_bad++;
        @(posedge clk);
        #1;
        valid_in = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
        funct3 = 3'($urandom);
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat = k; res = result; rdo = rd_out;
                end
            end
            if (busy !== (k < exp_lat)) busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_in = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        #1 rst = 1'b1;
        valid_in = 1'b1; rs1 = 32'd5; rs2 = 32'd3; rd_in = 5'd4;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_out); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (rd_out !== 5'h0) begin n_bad++; $display("FAIL reset_rd got %h want 0", rd_out); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_held got %b want 0", busy); end
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3v [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6};
        logic [31:0] av  [10] = '{32'd7, MIN_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] bv  [10] = '{32'hFFFF_FFFD, MIN_NEG, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] ev  [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5};
        int          lv  [10] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1};
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bb, nv;
        for (int i = 0; i < 10; i++) begin
            issue_op(f3v[i], av[i], bv[i], 5'(i + 1), lv[i], res, rdo, lat, bb, nv);
            n_cmp++; if (res !== ev[i]) begin n_bad++; $display("FAIL directed_result[%0d] got %h want %h", i, res, ev[i]); end
            n_cmp++; if (lat != lv[i]) begin n_bad++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, lv[i]); end
            n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL directed_busy[%0d] got %0d bad cycles want 0", i, bb); end
            n_cmp++; if (nv != 1) begin n_bad++; $display("FAIL directed_strobes[%0d] got %0d want 1", i, nv); end
            n_cmp++; if (rdo !== 5'(i + 1)) begin n_bad++; $display("FAIL directed_rd[%0d] got %0d want %0d", i, rdo, i + 1); end
        end
    endtask

    task automatic test_div_overflow();
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bb, nv;
        issue_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd20, 1, res, rdo, lat, bb, nv);
        n_cmp++; if (res !== MIN_NEG) begin n_bad++; $display("FAIL div_ovf_result got %h want %h", res, MIN_NEG); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
        issue_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd21, 1, res, rdo, lat, bb, nv);
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL rem_ovf_result got %h want 0", res); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rem_ovf_latency got %0d want 1", lat); end
        n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL rem_ovf_busy got %0d bad cycles want 0", bb); end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp;
        logic [2:0]  f3;
        logic [4:0]  rd, rdo;
        int lat, bb, nv, el;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
            exp = ref_model(f3, a, b);
            el  = ref_latency(f3, a, b);
            issue_op(f3, a, b, rd, el, res, rdo, lat, bb, nv);
            n_cmp++;
            if (res !== exp || lat != el || bb != 0 || nv != 1 || rdo !== rd) begin
                n_bad++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h got res=%h lat=%0d busybad=%0d n=%0d rd=%0d want res=%h lat=%0d n=1 rd=%0d",
                         i, f3, a, b, res, lat, bb, nv, rdo, exp, el, rd);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, bb, nv;
        valid_in = 1'b1; funct3 = 3'd5; rs1 = $urandom; rs2 = 32'($urandom_range(1, 1000)); rd_in = 5'd7;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_calc got %b want 1", busy); end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after got %b want 0", busy); end
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out === 1'b1) nv++;
        end
        n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL flush_no_strobe got %0d want 0", nv); end
        issue_op(3'd5, 32'd9, 32'd3, 5'd12, 33, res, rdo, lat, bb, nv);
        n_cmp++; if (res !== 32'd3) begin n_bad++; $display("FAIL flush_next_result got %h want 3", res); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL flush_next_latency got %0d want 33", lat); end
    endtask

    task automatic test_rst_mid();
        int nv, nb;
        valid_in = 1'b1; funct3 = 3'd0; rs1 = $urandom; rs2 = $urandom; rd_in = 5'd9;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid_out); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", result); end
        n_cmp++; if (rd_out !== 5'h0) begin n_bad++; $display("FAIL rstmid_rd got %h want 0", rd_out); end
        @(negedge clk);
        rst = 1'b0;
        nv = 0; nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out === 1'b1) nv++;
            if (busy !== 1'b0) nb++;
        end
        n_cmp++; if (nv != 0 || nb != 0) begin n_bad++; $display("FAIL rstmid_after got strobes=%0d busy=%0d want 0/0", nv, nb); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp, r;
        logic [2:0]  f3;
        logic [4:0]  rd, ro;
        logic        bdone;
        int          nv, k;
        for (int t = 0; t < 3; t++) begin
            f3 = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom_range(1, 31));
            exp = ref_model(f3, a, b);
            valid_in = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
            nv = 0; k = 0; r = '0; ro = '0; bdone = 1'bx;
            while (nv == 0 && k < 80) begin
                @(negedge clk);
                k++;
                if (valid_out === 1'b1) begin
                    nv = 1; r = result; ro = rd_out; bdone = busy;
                end
            end
            // pipeline advances on the DONE edge
            @(posedge clk);
            #1 valid_in = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (valid_out === 1'b1) nv++;
            end
            n_cmp++; if (nv != 1) begin n_bad++; $display("FAIL b2b_strobes[%0d] got %0d want 1", t, nv); end
            n_cmp++; if (r !== exp) begin n_bad++; $display("FAIL b2b_result[%0d] got %h want %h", t, r, exp); end
            n_cmp++; if (ro !== rd) begin n_bad++; $display("FAIL b2b_rd[%0d] got %0d want %0d", t, ro, rd); end
            n_cmp++; if (bdone !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_done[%0d] got %b want 0", t, bdone); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_overflow();
        test_random();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
